// File: rtl/ray_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ray_sched_pkg
// Description : Shared screen geometry, Q8.8 pose width and scheduler states.
// Revision    : 1.0 - initial release
// ============================================================================
package ray_sched_pkg;

    localparam int SCREEN_WIDTH = 320;
    localparam int HCOUNT_W     = 9;
    localparam int POSE_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/cycle_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : cycle_watchdog
// Description : Saturating cycle counter; expired holds once LIMIT is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               c_cnt_w = $clog2(LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(LIMIT);

    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != c_limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == c_limit);

endmodule
`default_nettype wire

// File: rtl/ray_column_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ray_column_scheduler
// Description : Per-frame column walker that issues ray calculations and gates
//               the calculator result handshake into the DDA FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ray_column_scheduler #(
    parameter int SCREEN_WIDTH   = ray_sched_pkg::SCREEN_WIDTH,
    parameter int HCOUNT_W       = ray_sched_pkg::HCOUNT_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             pixel_clk_in,
    input  logic                             rst_in,
    input  logic                             frame_start_in,
    input  logic [ray_sched_pkg::POSE_W-1:0] posX_in,
    input  logic [ray_sched_pkg::POSE_W-1:0] posY_in,
    input  logic [ray_sched_pkg::POSE_W-1:0] dirX_in,
    input  logic [ray_sched_pkg::POSE_W-1:0] dirY_in,
    input  logic [ray_sched_pkg::POSE_W-1:0] planeX_in,
    input  logic [ray_sched_pkg::POSE_W-1:0] planeY_in,
    output logic [ray_sched_pkg::POSE_W-1:0] posX_out,
    output logic [ray_sched_pkg::POSE_W-1:0] posY_out,
    output logic [ray_sched_pkg::POSE_W-1:0] dirX_out,
    output logic [ray_sched_pkg::POSE_W-1:0] dirY_out,
    output logic [ray_sched_pkg::POSE_W-1:0] planeX_out,
    output logic [ray_sched_pkg::POSE_W-1:0] planeY_out,
    output logic [HCOUNT_W-1:0]              hcount_out,
    output logic                             start_ray_calc_out,
    input  logic                             ray_busy_in,
    input  logic                             ray_valid_in,
    output logic                             ray_ready_out,
    input  logic                             fifo_ready_in,
    output logic                             busy_out,
    output logic                             frame_done_out,
    output logic                             overrun_out,
    output logic                             timeout_out
);

    import ray_sched_pkg::*;

    localparam logic [HCOUNT_W-1:0] c_last_col = HCOUNT_W'(SCREEN_WIDTH - 1);

    sched_state_t            state_q,   state_d;
    logic [HCOUNT_W-1:0]     hcount_q,  hcount_d;
    logic [6*POSE_W-1:0]     pose_q,    pose_d;
    logic                    timeout_q, timeout_d;
    logic                    overrun_q, overrun_d;

    logic w_start;
    logic w_ready;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expired;

    cycle_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (pixel_clk_in),
        .rst     (rst_in),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        hcount_d    = hcount_q;
        pose_d      = pose_q;
        timeout_d   = timeout_q;
        overrun_d   = frame_start_in && (state_q != ST_IDLE);
        w_start     = 1'b0;
        w_ready     = 1'b0;
        w_wd_clear  = 1'b0;
        w_wd_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start_in) begin
                    pose_d    = {posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in};
                    hcount_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!ray_busy_in) begin
                    w_start    = 1'b1;
                    w_wd_clear = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A valid held back by the FIFO is a downstream stall, not a hang.
                if (w_wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    w_ready     = fifo_ready_in;
                    w_wd_enable = !ray_valid_in;
                    if (ray_valid_in && fifo_ready_in) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!ray_valid_in) begin
                    if (hcount_q == c_last_col) begin
                        state_d = ST_DONE;
                    end else begin
                        hcount_d = hcount_q + 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            hcount_q  <= '0;
            pose_q    <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcount_q  <= hcount_d;
            pose_q    <= pose_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign posX_out           = pose_q[6*POSE_W-1 -: POSE_W];
    assign posY_out           = pose_q[5*POSE_W-1 -: POSE_W];
    assign dirX_out           = pose_q[4*POSE_W-1 -: POSE_W];
    assign dirY_out           = pose_q[3*POSE_W-1 -: POSE_W];
    assign planeX_out         = pose_q[2*POSE_W-1 -: POSE_W];
    assign planeY_out         = pose_q[POSE_W-1   -: POSE_W];
    assign hcount_out         = hcount_q;
    assign start_ray_calc_out = w_start;
    assign ray_ready_out      = w_ready;
    assign busy_out           = (state_q != ST_IDLE);
    assign frame_done_out     = (state_q == ST_DONE);
    assign overrun_out        = overrun_q;
    assign timeout_out        = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ray_column_scheduler.sv
`default_nettype none
// Scoreboard bench for ray_column_scheduler with a behavioural ray calculator
// and randomized FIFO back-pressure.
`timescale 1ns/1ps
module tb_ray_column_scheduler;

    localparam int NCOL = 320;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        frame_start_in = 1'b0;
    logic [15:0] posX_in = '0, posY_in = '0, dirX_in = '0, dirY_in = '0, planeX_in = '0, planeY_in = '0;
    logic [15:0] posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out;
    logic [8:0]  hcount_out;
    logic        start_ray_calc_out, ray_ready_out, busy_out, frame_done_out, overrun_out, timeout_out;
    logic        ray_busy_in = 1'b0;
    logic        ray_valid_in = 1'b0;
    logic        fifo_ready_in = 1'b1;
    logic [95:0] pose_out_w;

    always #5 pixel_clk_in = ~pixel_clk_in;

    ray_column_scheduler dut (
        .pixel_clk_in       (pixel_clk_in),
        .rst_in             (rst_in),
        .frame_start_in     (frame_start_in),
        .posX_in            (posX_in),
        .posY_in            (posY_in),
        .dirX_in            (dirX_in),
        .dirY_in            (dirY_in),
        .planeX_in          (planeX_in),
        .planeY_in          (planeY_in),
        .posX_out           (posX_out),
        .posY_out           (posY_out),
        .dirX_out           (dirX_out),
        .dirY_out           (dirY_out),
        .planeX_out         (planeX_out),
        .planeY_out         (planeY_out),
        .hcount_out         (hcount_out),
        .start_ray_calc_out (start_ray_calc_out),
        .ray_busy_in        (ray_busy_in),
        .ray_valid_in       (ray_valid_in),
        .ray_ready_out      (ray_ready_out),
        .fifo_ready_in      (fifo_ready_in),
        .busy_out           (busy_out),
        .frame_done_out     (frame_done_out),
        .overrun_out        (overrun_out),
        .timeout_out        (timeout_out)
    );

    assign pose_out_w = {posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out};

    typedef struct packed {
        logic [8:0]  col;
        logic [95:0] pose;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    int          n_start = 0, n_hs = 0, n_done = 0, n_ovr = 0;
    int          b_start = 0, b_hs = 0, b_done = 0, b_ovr = 0;
    int          last_start_cyc = 0;
    logic [95:0] cur_pose = '0;

    // calculator model knobs
    int lat_min = 1, lat_max = 1, stuck_col = -1, stall_cnt = 0;
    bit stall_en = 1'b0;

    always @(posedge pixel_clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural calculator: busy for a random latency after a start, then
    // presents valid until accepted. Reacts to what the DUT saw at the last edge.
    bit s_rst = 1'b1, s_start = 1'b0, s_hs = 1'b0;
    int s_col = 0, m_cnt = 0, m_col = 0;
    always begin
        @(negedge pixel_clk_in);
        if (s_rst) begin
            ray_busy_in  = 1'b0;
            ray_valid_in = 1'b0;
            m_cnt        = 0;
        end else begin
            if (s_hs) ray_valid_in = 1'b0;
            if (s_start) begin
                ray_busy_in = 1'b1;
                m_cnt       = int'($urandom_range(lat_max, lat_min));
                m_col       = s_col;
            end else if (ray_busy_in) begin
                if (m_cnt > 1) m_cnt--;
                else begin
                    ray_busy_in = 1'b0;
                    if (m_col != stuck_col) ray_valid_in = 1'b1;
                end
            end
        end
        if (stall_cnt > 0) begin
            fifo_ready_in = 1'b0;
            stall_cnt--;
        end else begin
            fifo_ready_in = 1'b1;
            if (stall_en && ($urandom_range(15, 0) == 0)) stall_cnt = int'($urandom_range(50, 0));
        end
        #3;
        s_rst   = rst_in;
        s_start = start_ray_calc_out;
        s_hs    = ray_valid_in & ray_ready_out;
        s_col   = int'(hcount_out);
    end

    // Monitor: pops the scoreboard on every start pulse, tracks events.
    bit ovr_pending = 1'b0, prev_done = 1'b0;
    always begin
        exp_t e;
        @(negedge pixel_clk_in);
        #4;
        if (!rst_in) begin
            if (start_ray_calc_out) begin
                n_start++;
                last_start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_start: got hcount %0d, expected no start (cycle %0d)", hcount_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("hcount_order", 128'(hcount_out), 128'(e.col));
                    chk("pose_at_start", 128'(pose_out_w), 128'(e.pose));
                end
            end
            if (ray_valid_in && ray_ready_out) n_hs++;
            if (frame_done_out) n_done++;
            if (overrun_out) n_ovr++;
        end
        if (ovr_pending || overrun_out) chk("overrun_timing", 128'(overrun_out), 128'(ovr_pending));
        ovr_pending = frame_start_in && busy_out && !rst_in;
        if (prev_done) chk("busy_after_done", 128'(busy_out), 128'(0));
        prev_done = frame_done_out && !rst_in;
        if (busy_out) chk("pose_hold", 128'(pose_out_w), 128'(cur_pose));
    end

    task automatic step();
        @(negedge pixel_clk_in);
        #1;
    endtask

    task automatic set_live(input logic [95:0] p);
        {posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in} = p;
    endtask

    task automatic rand_live();
        set_live({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic snap();
        b_start = n_start; b_hs = n_hs; b_done = n_done; b_ovr = n_ovr;
    endtask

    task automatic start_frame(input logic [95:0] p);
        set_live(p);
        frame_start_in = 1'b1;
        cur_pose = p;
        for (int c = 0; c < NCOL; c++) exp_q.push_back('{col: 9'(c), pose: p});
        step();
        frame_start_in = 1'b0;
        rand_live();
    endtask

    task automatic wait_done(input int budget, input bit inject, output bit ok);
        bit did = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            frame_start_in = 1'b0;
            rand_live();
            if (inject && !did && busy_out && (hcount_out == 9'd100)) begin
                frame_start_in = 1'b1;
                did = 1'b1;
            end
            if (frame_done_out) begin
                ok = 1'b1;
                if (inject) frame_start_in = 1'b1;
                break;
            end
        end
        step();
        frame_start_in = 1'b0;
        step();
    endtask

    task automatic frame_checks(input string tag, input int exp_ovr);
        chk({tag, "_starts"},   128'(n_start - b_start), 128'(NCOL));
        chk({tag, "_handshakes"}, 128'(n_hs - b_hs),     128'(NCOL));
        chk({tag, "_done"},     128'(n_done - b_done),   128'(1));
        chk({tag, "_overruns"}, 128'(n_ovr - b_ovr),     128'(exp_ovr));
        chk({tag, "_sb_left"},  128'(exp_q.size()),      128'(0));
        chk({tag, "_timeout"},  128'(timeout_out),       128'(0));
        chk({tag, "_idle"},     128'(busy_out),          128'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"},   128'(start_ray_calc_out), 128'(0));
        chk({tag, "_ready"},   128'(ray_ready_out),      128'(0));
        chk({tag, "_busy"},    128'(busy_out),           128'(0));
        chk({tag, "_done"},    128'(frame_done_out),     128'(0));
        chk({tag, "_overrun"}, 128'(overrun_out),        128'(0));
        chk({tag, "_timeout"}, 128'(timeout_out),        128'(0));
        chk({tag, "_hcount"},  128'(hcount_out),         128'(0));
        chk({tag, "_pose"},    128'(pose_out_w),         128'(0));
    endtask

    initial begin
        bit ok;
        int dly;

        repeat (3) step();
        rst_in = 1'b0;
        check_all_zero("reset");
        repeat (20) step();
        check_all_zero("idle");
        chk("idle_no_starts", 128'(n_start), 128'(0));

        // frame request coincident with reset is swallowed by the reset
        frame_start_in = 1'b1;
        rst_in = 1'b1;
        step();
        frame_start_in = 1'b0;
        rst_in = 1'b0;
        chk("rst_wins_busy", 128'(busy_out), 128'(0));
        step();
        chk("rst_wins_busy2", 128'(busy_out), 128'(0));
        chk("rst_wins_overrun", 128'(overrun_out), 128'(0));

        // nominal frame: fixed 30-cycle calculator, FIFO always ready
        lat_min = 30; lat_max = 30;
        snap();
        start_frame({16'h0380, 16'h0280, 16'hFF00, 16'h0000, 16'h0000, 16'h00A8});
        wait_done(20000, 1'b0, ok);
        chk("f1_completed", 128'(ok), 128'(1));
        frame_checks("f1", 0);

        // random FIFO back-pressure
        lat_min = 1; lat_max = 8; stall_en = 1'b1;
        snap();
        start_frame({$urandom(), $urandom(), $urandom()});
        wait_done(40000, 1'b0, ok);
        stall_en = 1'b0;
        chk("stall_completed", 128'(ok), 128'(1));
        frame_checks("stall", 0);

        // frame requests at column 100 and in the DONE cycle are dropped
        lat_min = 1; lat_max = 6;
        snap();
        start_frame({$urandom(), $urandom(), $urandom()});
        wait_done(20000, 1'b1, ok);
        chk("ovr_completed", 128'(ok), 128'(1));
        frame_checks("ovr", 2);

        // calculator hangs at column 5
        lat_min = 1; lat_max = 4; stuck_col = 5;
        snap();
        start_frame({$urandom(), $urandom(), $urandom()});
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            rand_live();
            if (timeout_out) begin
                ok = 1'b1;
                break;
            end
        end
        dly = cyc - last_start_cyc;
        chk("wd_fired", 128'(ok), 128'(1));
        chk("wd_delay_window", 128'((dly >= 1024) && (dly <= 1028)), 128'(1));
        chk("wd_idle", 128'(busy_out), 128'(0));
        chk("wd_no_done", 128'(n_done - b_done), 128'(0));
        chk("wd_starts", 128'(n_start - b_start), 128'(6));
        chk("wd_handshakes", 128'(n_hs - b_hs), 128'(5));
        exp_q.delete();
        stuck_col = -1;
        repeat (3) step();
        chk("wd_sticky", 128'(timeout_out), 128'(1));
        snap();
        start_frame({$urandom(), $urandom(), $urandom()});
        chk("wd_cleared", 128'(timeout_out), 128'(0));
        wait_done(20000, 1'b0, ok);
        chk("wd_next_completed", 128'(ok), 128'(1));
        frame_checks("wd_next", 0);

        // reset mid-frame at column 200 while the calculator presents valid
        lat_min = 1; lat_max = 5;
        snap();
        start_frame({$urandom(), $urandom(), $urandom()});
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            step();
            rand_live();
            if ((hcount_out == 9'd200) && ray_valid_in) begin
                rst_in = 1'b1;
                ok = 1'b1;
                break;
            end
        end
        chk("rst_point_reached", 128'(ok), 128'(1));
        step();
        rst_in = 1'b0;
        check_all_zero("midrst");
        chk("midrst_starts", 128'(n_start - b_start), 128'(201));
        chk("midrst_handshakes", 128'(n_hs - b_hs), 128'(200));
        exp_q.delete();
        step();
        snap();
        start_frame({$urandom(), $urandom(), $urandom()});
        wait_done(20000, 1'b0, ok);
        chk("restart_completed", 128'(ok), 128'(1));
        frame_checks("restart", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ray_column_scheduler.md
# ray_column_scheduler

Frame-level sequencer for the per-column ray calculation stage. On each frame request it snapshots the player pose and camera plane and holds them stable for the whole frame. It then walks `hcount` from 0 to SCREEN_WIDTH-1, issuing one ray calculation per column and gating the calculator's output handshake into the downstream DDA FIFO. It reports frame completion, dropped frame requests, and a stalled calculator (watchdog).

## Interface
- SCREEN_WIDTH, 320, columns per frame
- HCOUNT_W, 9, column index width
- TIMEOUT_CYCLES, 1024, max cycles WAIT may see neither valid nor busy progress
- pixel_clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- frame_start_in  in  1  single-cycle frame request
- posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in  in  16 each  live pose, Q8.8
- posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out  out  16 each  frame-latched pose to calculator
- hcount_out  out  HCOUNT_W  current column to calculator
- start_ray_calc_out  out  1  one-cycle start pulse to calculator
- ray_busy_in  in  1  calculator busy
- ray_valid_in  in  1  calculator result valid
- ray_ready_out  out  1  drives calculator `dda_data_ready_out`
- fifo_ready_in  in  1  downstream DDA FIFO can accept
- busy_out  out  1  frame in progress
- frame_done_out  out  1  one-cycle pulse after last column accepted
- overrun_out  out  1  one-cycle pulse: frame_start_in dropped
- timeout_out  out  1  sticky watchdog flag, cleared by rst_in or next accepted frame_start_in

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE: on frame_start_in, latch all six pose inputs, set hcount_out=0, clear timeout_out, go to ISSUE.
- ISSUE: if ray_busy_in=0, pulse start_ray_calc_out for one cycle, clear watchdog, go to WAIT. Otherwise hold.
- WAIT: ray_ready_out = fifo_ready_in (combinational). The handshake is ray_valid_in & ray_ready_out; on handshake go to DRAIN.
- DRAIN: ray_ready_out=0. Wait for ray_valid_in=0 so the same result is never counted twice. Then, if hcount_out = SCREEN_WIDTH-1, go to DONE; otherwise increment hcount_out and go to ISSUE.
- DONE: pulse frame_done_out, go to IDLE.
- Watchdog: counts in WAIT only while ray_valid_in=0; reset on entering WAIT. A valid held by fifo_ready_in=0 is a downstream stall and is not counted. On reaching TIMEOUT_CYCLES: set timeout_out, force ray_ready_out=0, go to IDLE with no frame_done_out.
- ray_ready_out is 0 in every state other than WAIT.
- busy_out=1 in ISSUE, WAIT, DRAIN, DONE.
- Pose outputs change only on an accepted frame_start_in; live input changes mid-frame are ignored.
- hcount_out never exceeds SCREEN_WIDTH-1 and does not wrap inside a frame.

## Timing
- Reset: state IDLE; all outputs 0, including pose outputs, hcount_out and timeout_out.
- frame_start_in at cycle T in IDLE: pose latched and state ISSUE at T+1. If ray_busy_in=0, start_ray_calc_out is high during T+1.
- A handshake at cycle H gives DRAIN from H+1. With the calculator dropping valid at H+1, the next ISSUE is at H+2 and the next start pulse no earlier than H+2.
- frame_done_out is high exactly one cycle. busy_out falls the cycle after it.
- frame_start_in while busy_out=1, including the DONE cycle: dropped, overrun_out pulses in the same cycle plus one.
- frame_start_in coincident with rst_in: reset wins, no overrun_out.
- Reset mid-frame: next cycle IDLE, start_ray_calc_out=0, ray_ready_out=0. The calculator is also reset by the shared rst_in.
- fifo_ready_in toggling in WAIT: no handshake until valid and ready are high in the same cycle. The result is held.

## Structure
- Package `ray_sched_pkg`: state enum, SCREEN_WIDTH, HCOUNT_W, Q8.8 pose width (16), shared with ray calculation and DDA blocks.
- One sub-module: `cycle_watchdog` (parameter LIMIT; inputs clear, enable; output expired), a saturating counter.
- Top-level instantiation: scheduler drives the calculator's hcount, pose, start and ready inputs, and observes its busy and valid outputs.

## Test plan
- Reset, then idle 20 cycles -> all outputs 0, busy_out=0, no start pulses.
- frame_start_in with pose 0x0380/0x0280/0xFF00/0/0/0x00A8, calculator model with a 30-cycle latency and fifo_ready_in=1 -> exactly 320 start pulses, hcount 0..319 in order, 320 handshakes, pose outputs constant, one frame_done_out.
- Random 0-50-cycle fifo_ready_in=0 stalls during a frame -> no duplicated or lost handshake (count=320), watchdog silent.
- frame_start_in at column 100, and again in the DONE cycle -> overrun_out pulses twice, hcount sequence undisturbed, pose unchanged.
- Calculator model never asserts valid at column 5 -> timeout_out=1 after 1024 WAIT cycles, state IDLE, no frame_done_out; next frame_start_in clears timeout_out.
- rst_in asserted at column 200 while ray_valid_in=1 -> next cycle all outputs 0; a new frame restarts at hcount 0.
